// File: rtl/apb_slave_regfile.sv
// APB slave register file: DEPTH x DATA_WIDTH registers with fixed wait states.
// Out-of-range addresses and simultaneous pwrite/pread are answered with pslverr.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic                  pread,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    logic                  write_q, write_next;
    logic                  read_q, read_next;
    logic [DATA_WIDTH-1:0] prdata_next;
    logic                  pready_next, pslverr_next;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // With zero wait states the response is built on the SETUP edge, so the
    // transfer attributes come straight from the bus rather than the latches.
    logic [ADDR_WIDTH-1:0] eval_addr;
    logic                  eval_write, eval_read, eval_err;
    logic [IDX_W-1:0]      eval_idx;
    logic [DATA_WIDTH-1:0] eval_rdata;

    always_comb begin
        eval_addr  = (state == IDLE) ? paddr  : addr_q;
        eval_write = (state == IDLE) ? pwrite : write_q;
        eval_read  = (state == IDLE) ? pread  : read_q;
        eval_idx   = eval_addr[IDX_W-1:0];
        eval_err   = ({1'b0, eval_addr} >= DEPTH_L) || (eval_write && eval_read);
        eval_rdata = (!eval_err && !eval_write) ? mem[eval_idx] : '0;
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        addr_next    = addr_q;
        data_next    = data_q;
        write_next   = write_q;
        read_next    = read_q;
        prdata_next  = prdata;
        pready_next  = pready;
        pslverr_next = pslverr;
        mem_we       = 1'b0;

        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    addr_next  = paddr;
                    data_next  = pwdata;
                    write_next = pwrite;
                    read_next  = pread;
                    cnt_next   = WAIT_L;
                    if (WAIT_L == 4'd0) begin
                        state_next   = DONE;
                        pready_next  = 1'b1;
                        pslverr_next = eval_err;
                        prdata_next  = eval_rdata;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next   = IDLE;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    prdata_next  = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_next   = DONE;
                        pready_next  = 1'b1;
                        pslverr_next = eval_err;
                        prdata_next  = eval_rdata;
                    end
                end
            end
            DONE: begin
                if (!psel || penable) begin
                    mem_we       = psel && write_q && !read_q && !pslverr;
                    state_next   = IDLE;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    prdata_next  = '0;
                end
            end
            default: begin
                state_next   = IDLE;
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                prdata_next  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            addr_q  <= addr_next;
            data_q  <= data_next;
            write_q <= write_next;
            read_q  <= read_next;
            prdata  <= prdata_next;
            pready  <= pready_next;
            pslverr <= pslverr_next;
        end
    end

    // pslverr already excludes out-of-range addresses, so the index is safe here.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr_q[IDX_W-1:0]] <= data_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with 2 wait states, one with 0.
// Each test task drives the bus and compares against hand-computed values.
module tb_apb_slave_regfile;

    logic       pclk;
    logic       prstn;
    logic       psel_a, psel_b, penable, pwrite, pread;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata_a, prdata_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;

    int checks;
    int failures;
    int cycle;
    int b_ready_cnt;
    logic [7:0] exp_mem [16];

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) dut_a (
        .pclk(pclk), .prstn(prstn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .pread(pread), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
        .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut_b (
        .pclk(pclk), .prstn(prstn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .pread(pread), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .pready(pready_b), .pslverr(pslverr_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cycle++;
    always @(negedge pclk) if (pready_b === 1'b1) b_ready_cnt++;

    // Full transfer, entered and left 1 time unit after a rising edge so calls chain back-to-back.
    task automatic apb_xfer(input bit to_b, input bit wr, input bit rd, input logic [7:0] addr,
                            input logic [7:0] data, output logic [7:0] rdata, output logic err,
                            output int waits, output logic ready_after, output bit timeout);
        paddr   = addr;
        pwdata  = data;
        pwrite  = wr;
        pread   = rd;
        penable = 1'b0;
        psel_a  = !to_b;
        psel_b  = to_b;
        @(posedge pclk);
        #1 penable = 1'b1;
        waits   = 0;
        timeout = 1'b0;
        while (((to_b ? pready_b : pready_a) !== 1'b1) && !timeout) begin
            @(posedge pclk);
            #1;
            waits++;
            if (waits > 20) timeout = 1'b1;
        end
        rdata = to_b ? prdata_b : prdata_a;
        err   = to_b ? pslverr_b : pslverr_a;
        @(posedge pclk);
        #1;
        ready_after = to_b ? pready_b : pready_a;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        prstn = 1'b1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pread = 1'b0; paddr = '0; pwdata = '0;
        #2 prstn = 1'b0;
        #1;
        checks++;
        if ({pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b} !== 18'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h required=0",
                     {pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b});
        end
        repeat (2) @(posedge pclk);
        #1 prstn = 1'b1;
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h00 || err !== 1'b0 || to) begin
            failures++;
            $display("[TB] FAIL reset_read0 got=%h err=%b timeout=%b required=00 err=0", rd, err, to);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic test_wait_states();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        apb_xfer(1'b0, 1'b1, 1'b0, 8'd3, 8'hA5, rd, err, w, ra, to);
        exp_mem[3] = 8'hA5;
        checks++;
        if (w !== 2 || to) begin
            failures++;
            $display("[TB] FAIL ws_write_waits got=%0d timeout=%b required=2", w, to);
        end
        checks++;
        if (err !== 1'b0 || rd !== 8'h00 || ra !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ws_write_resp got err=%b prdata=%h ready_after=%b required 0/00/0", err, rd, ra);
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd3, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'hA5 || err !== 1'b0 || w !== 2) begin
            failures++;
            $display("[TB] FAIL ws_readback got=%h err=%b waits=%0d required=a5 err=0 waits=2", rd, err, w);
        end
        apb_xfer(1'b0, 1'b0, 1'b0, 8'd3, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'hA5 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ws_read_no_strobe got=%h err=%b required=a5 err=0", rd, err);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        apb_xfer(1'b0, 1'b1, 1'b0, 8'h20, 8'hFF, rd, err, w, ra, to);
        checks++;
        if (err !== 1'b1 || to) begin
            failures++;
            $display("[TB] FAIL oor_write_err got=%b timeout=%b required=1", err, to);
        end
        apb_xfer(1'b0, 1'b1, 1'b0, 8'h10, 8'hEE, rd, err, w, ra, to);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL oor_write16_err got=%b required=1", err);
        end
        apb_xfer(1'b0, 1'b1, 1'b0, 8'h0F, 8'h0F, rd, err, w, ra, to);
        exp_mem[15] = 8'h0F;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_write15_err got=%b required=0", err);
        end
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b0, 1'b0, 1'b1, 8'(i), 8'h00, rd, err, w, ra, to);
            checks++;
            if (rd !== exp_mem[i] || err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL oor_scan addr=%0d got=%h err=%b required=%h err=0", i, rd, err, exp_mem[i]);
            end
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'h20, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h00 || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL oor_read got=%h err=%b required=00 err=1", rd, err);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        apb_xfer(1'b0, 1'b1, 1'b0, 8'd1, 8'hC3, rd, err, w, ra, to);
        exp_mem[1] = 8'hC3;
        apb_xfer(1'b0, 1'b1, 1'b1, 8'd1, 8'h11, rd, err, w, ra, to);
        checks++;
        if (err !== 1'b1 || rd !== 8'h00) begin
            failures++;
            $display("[TB] FAIL conflict_err got err=%b prdata=%h required err=1 prdata=00", err, rd);
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd1, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'hC3 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL conflict_readback got=%h err=%b required=c3 err=0", rd, err);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        logic       seen;
        apb_xfer(1'b0, 1'b1, 1'b0, 8'd4, 8'h4E, rd, err, w, ra, to);
        exp_mem[4] = 8'h4E;
        paddr = 8'd4; pwdata = 8'h77; pwrite = 1'b1; pread = 1'b0;
        psel_a = 1'b1; penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 psel_a = 1'b0;
        penable = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge pclk);
            #1 seen = seen | pready_a;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_pready got=%b required=0", seen);
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd4, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h4E) begin
            failures++;
            $display("[TB] FAIL abort_mem got=%h required=4e", rd);
        end
        apb_xfer(1'b0, 1'b1, 1'b0, 8'd4, 8'h33, rd, err, w, ra, to);
        exp_mem[4] = 8'h33;
        checks++;
        if (err !== 1'b0 || w !== 2 || to) begin
            failures++;
            $display("[TB] FAIL abort_rewrite got err=%b waits=%0d required err=0 waits=2", err, w);
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd4, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h33) begin
            failures++;
            $display("[TB] FAIL abort_rewrite_read got=%h required=33", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd0, rd1, rd;
        logic       err, ra;
        int         w, c0, c1;
        bit         to;
        b_ready_cnt = 0;
        c0 = cycle;
        apb_xfer(1'b1, 1'b1, 1'b0, 8'd0, 8'h01, rd, err, w, ra, to);
        apb_xfer(1'b1, 1'b1, 1'b0, 8'd1, 8'h02, rd, err, w, ra, to);
        apb_xfer(1'b1, 1'b0, 1'b1, 8'd0, 8'h00, rd0, err, w, ra, to);
        apb_xfer(1'b1, 1'b0, 1'b1, 8'd1, 8'h00, rd1, err, w, ra, to);
        c1 = cycle;
        checks++;
        if (c1 - c0 !== 8) begin
            failures++;
            $display("[TB] FAIL b2b_cycles got=%0d required=8", c1 - c0);
        end
        checks++;
        if (rd0 !== 8'h01 || rd1 !== 8'h02) begin
            failures++;
            $display("[TB] FAIL b2b_readback got=%h,%h required=01,02", rd0, rd1);
        end
        checks++;
        if (b_ready_cnt !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_pready_pulses got=%0d required=4", b_ready_cnt);
        end
        checks++;
        if (ra !== 1'b0 || w !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_ready_shape got ready_after=%b waits=%0d required 0/0", ra, w);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] rd;
        logic       err, ra;
        int         w;
        bit         to;
        apb_xfer(1'b0, 1'b1, 1'b0, 8'd2, 8'h44, rd, err, w, ra, to);
        // reset while a read response is being presented
        paddr = 8'd3; pwrite = 1'b0; pread = 1'b1; psel_a = 1'b1; penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        w = 0;
        while (pready_a !== 1'b1 && w < 20) begin
            @(posedge pclk);
            #1 w++;
        end
        checks++;
        if (prdata_a !== 8'hA5 || pready_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_done_pre got=%h ready=%b required=a5 ready=1", prdata_a, pready_a);
        end
        #2 prstn = 1'b0;
        #1;
        checks++;
        if ({pready_a, pslverr_a, prdata_a} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL rst_done_outputs got=%h required=0", {pready_a, pslverr_a, prdata_a});
        end
        @(posedge pclk);
        #1 prstn = 1'b1;
        psel_a = 1'b0; penable = 1'b0;
        // reset in the second ACCESS cycle of a write
        paddr = 8'd2; pwdata = 8'h5A; pwrite = 1'b1; pread = 1'b0; psel_a = 1'b1;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 prstn = 1'b0;
        #1;
        checks++;
        if ({pready_a, pslverr_a, prdata_a} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL rst_access_outputs got=%h required=0", {pready_a, pslverr_a, prdata_a});
        end
        @(posedge pclk);
        #1 prstn = 1'b1;
        psel_a = 1'b0; penable = 1'b0;
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd2, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h00 || err !== 1'b0 || to) begin
            failures++;
            $display("[TB] FAIL rst_read2 got=%h err=%b required=00 err=0", rd, err);
        end
        apb_xfer(1'b0, 1'b0, 1'b1, 8'd3, 8'h00, rd, err, w, ra, to);
        checks++;
        if (rd !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_read3 got=%h required=00", rd);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cycle = 0;
        b_ready_cnt = 0;
        test_reset();
        test_wait_states();
        test_out_of_range();
        test_conflict();
        test_abort();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Synthesizable APB slave that terminates the team's APB bus: a DEPTH x DATA_WIDTH register file answering the master's setup/access transfers with `pready`, `prdata` and `pslverr`. It is the DUT-side consumer of everything the master driver puts on the bus, and the producer of every signal the slave monitor checks. Wait states are fixed by parameter. Out-of-range addresses and conflicting direction strobes are reported as slave errors.

## Interface
- `ADDR_WIDTH`, 8: width of `paddr`.
- `DATA_WIDTH`, 8: width of `pwdata` and `prdata`.
- `DEPTH`, 16: number of registers. Legal addresses are 0..DEPTH-1. DEPTH must not exceed 2^ADDR_WIDTH.
- `WAIT_STATES`, 1: number of `pready`-low ACCESS cycles before completion. Range is 0..15.

Ports:
- `pclk` in 1: the single clock; all state updates on its rising edge.
- `prstn` in 1: reset, asynchronous and active-low.
- `psel` in 1: slave select.
- `penable` in 1: ACCESS phase strobe.
- `pwrite` in 1: 1 means write.
- `pread` in 1: 1 means read. `pwrite` and `pread` both 1 is an error. Both 0 is treated as a read.
- `paddr` in ADDR_WIDTH: transfer address.
- `pwdata` in DATA_WIDTH: write data.
- `prdata` out DATA_WIDTH: read data. Registered.
- `pready` out 1: transfer completion. Registered.
- `pslverr` out 1: transfer error. Registered. Valid only while `pready`=1.

## Operation
- FSM states:
  - IDLE: no transfer in progress.
  - WAIT: setup captured; counting wait states.
  - DONE: `pready` asserted.
- IDLE → WAIT on any edge sampling `psel`=1 and `penable`=0 (SETUP).
  - `paddr`, `pwdata`, `pwrite` and `pread` are latched at that edge.
  - The wait counter is loaded with WAIT_STATES.
  - Bus inputs are ignored from then until the transfer ends, except `psel`.
- `psel`=1 with `penable`=1 sampled in IDLE (no prior setup) is ignored. The FSM stays in IDLE.
- In WAIT, the counter decrements each edge. The edge at which it would reach 0 moves the FSM to DONE.
  - With WAIT_STATES=0, the SETUP edge itself goes IDLE → DONE.
- At the edge entering DONE, `pready` is set to 1. On the same edge:
  - Error is computed from the latched values: address ≥ DEPTH, or `pwrite`=`pread`=1. It drives `pslverr`.
  - For a read without error, `prdata` is loaded with mem[addr].
  - Otherwise `prdata` is loaded with 0.
- DONE → IDLE at the next edge sampling `psel`=`penable`=1 (completion edge).
  - A write without error commits to mem[addr] on this edge.
  - `pready`, `pslverr` and `prdata` clear to 0 on this edge.
- Erroneous writes never modify memory.
- Abort: `psel`=0 sampled in WAIT or DONE returns the FSM to IDLE.
  - No write occurs.
  - Outputs clear to 0 on that edge.
- Back-to-back transfers: a SETUP sampled on the edge after completion starts a new transfer normally. No idle cycle is required.

## Timing
- Reset (`prstn`=0, asynchronous): the FSM goes to IDLE. `prdata`, `pready` and `pslverr` go to 0, and all DEPTH registers go to 0. This applies mid-transfer too: an in-flight write is dropped.
- Reset release is synchronous to `pclk`. The first SETUP is accepted on the first edge after deassertion.
- SETUP edge at T0:
  - `pready` rises at edge T0+WAIT_STATES.
  - Completion occurs at edge T0+WAIT_STATES+1.
  - The transfer occupies WAIT_STATES+1 ACCESS cycles, i.e. WAIT_STATES+2 bus cycles in total.
- Read data is visible to the master in the same cycle `pready`=1 (sampled at the completion edge).
- Write data is visible to a read whose SETUP is at or after the completion edge.
- The counter is 4 bits. Address comparison uses the full ADDR_WIDTH, with no truncation or wrap.

## Test plan
- Reset during transfer: WAIT_STATES=2; write 0x5A to addr 2; assert `prstn`=0 in the 2nd ACCESS cycle → all outputs 0 immediately. A subsequent read of addr 2 returns 0x00 with `pslverr`=0.
- Wait-state timing: WAIT_STATES=2; write 0xA5 to addr 3 with SETUP at T0 → `pready` 0 at T0+1 and T0+2, 1 at T0+3 (after edge T0+2), completion at T0+3. A read of addr 3 returns 0xA5 with `pslverr`=0.
- Out-of-range: write 0xFF to addr 0x20 → `pready`=1 with `pslverr`=1. Reads of 0..15 are unchanged. A read of 0x20 returns `prdata`=0x00 with `pslverr`=1.
- Direction conflict: `pwrite`=`pread`=1, addr 1, data 0x11 → `pslverr`=1. A read of addr 1 returns its prior value.
- Abort: WAIT_STATES=2; write 0x77 to addr 4; drop `psel` after 1 ACCESS cycle → `pready` never rises and mem[4] is unchanged. The next write of 0x33 to addr 4 completes normally.
- Back-to-back: WAIT_STATES=0; writes of 0x01 and 0x02 to addr 0 and 1, with SETUP on the cycle after each completion → each transfer takes 2 cycles. Readback gives 0x01 and 0x02, and `pready` pulses exactly one cycle per transfer.
